// File: rtl/crossbar_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_seq_if
// Description : Command / response handshake bundle for crossbar_seq.
//               master : command issuer and result consumer
//               slave  : crossbar sequencer
//   cmd_valid/cmd_ready   command handshake
//   cmd_op[1:0]           0 PROG, 1 FORM, 2 MAC, 3 reserved
//   cmd_row[2:0]          target row for PROG/FORM
//   cmd_data[7:0]         row weights (PROG/FORM) or input vector (MAC)
//   rsp_valid/rsp_ready   result handshake
//   rsp_data[7:0]         captured MAC result
// Revision    : 1.0 - initial release
// ============================================================================
interface crossbar_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_row;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/crossbar_seq.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_seq
// Description : Sequencer for an 8x8 resistive crossbar array. Converts
//               PROG / FORM / MAC commands into timed wordline, bitline and
//               selectline drive patterns and captures the thresholded
//               column result of a MAC read.
//   clk, rst        clock and synchronous active-high reset
//   bus (slave)     command / response handshake (crossbar_seq_if)
//   bitline         column bitline drive
//   wordline        row wordline drive
//   selectline      column selectline drive
//   wenable         write enable, high during PROG/FORM pulses
//   form            forming mode, high during FORM pulses
//   mac             read mode, high during read drive and wait
//   arr_out         thresholded column result from the array
//   busy            high whenever the sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_seq #(
   parameter int PULSE_CYCLES = 2,
   parameter int READ_LAT     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   crossbar_seq_if.slave        bus,
   output logic [7:0]           bitline,
   output logic [7:0]           wordline,
   output logic [7:0]           selectline,
   output logic                 wenable,
   output logic                 form,
   output logic                 mac,
   input  logic [7:0]           arr_out,
   output logic                 busy
);

   localparam logic [1:0] OP_PROG = 2'd0;
   localparam logic [1:0] OP_FORM = 2'd1;
   localparam logic [1:0] OP_MAC  = 2'd2;

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES);
   localparam logic [3:0] WAIT_LAST  = 4'(READ_LAT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PULSE = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t     state_q;
   logic [3:0] cnt_q;
   logic [1:0] op_q;
   logic [2:0] row_q;
   logic [7:0] data_q;
   logic [7:0] bitline_q;
   logic [7:0] wordline_q;
   logic [7:0] selectline_q;
   logic       wenable_q;
   logic       form_q;
   logic       mac_q;
   logic       rsp_valid_q;
   logic [7:0] rsp_data_q;
   logic       cmd_fire;

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign cmd_fire      = bus.cmd_valid && (state_q == S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         op_q         <= 2'd0;
         row_q        <= 3'd0;
         data_q       <= 8'h00;
         bitline_q    <= 8'h00;
         wordline_q   <= 8'h00;
         selectline_q <= 8'h00;
         wenable_q    <= 1'b0;
         form_q       <= 1'b0;
         mac_q        <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_fire) begin
                  op_q   <= bus.cmd_op;
                  row_q  <= bus.cmd_row;
                  data_q <= bus.cmd_data;
                  // Drive patterns launch from the raw command so the array
                  // sees them in the first cycle after the accept edge.
                  if (bus.cmd_op == OP_PROG || bus.cmd_op == OP_FORM) begin
                     state_q      <= S_PULSE;
                     cnt_q        <= 4'd1;
                     wordline_q   <= 8'd1 << bus.cmd_row;
                     bitline_q    <= bus.cmd_data;
                     selectline_q <= ~bus.cmd_data;
                     wenable_q    <= 1'b1;
                     form_q       <= (bus.cmd_op == OP_FORM);
                  end else if (bus.cmd_op == OP_MAC) begin
                     state_q    <= S_READ;
                     wordline_q <= bus.cmd_data;
                     mac_q      <= 1'b1;
                  end
                  // Reserved op: accepted and dropped, stay idle.
               end
            end

            S_PULSE: begin
               if (cnt_q >= PULSE_LAST) begin
                  state_q      <= S_IDLE;
                  cnt_q        <= 4'd0;
                  wordline_q   <= 8'h00;
                  bitline_q    <= 8'h00;
                  selectline_q <= 8'h00;
                  wenable_q    <= 1'b0;
                  form_q       <= 1'b0;
               end else begin
                  cnt_q        <= cnt_q + 4'd1;
                  // Hold the pattern from the latched command.
                  wordline_q   <= 8'd1 << row_q;
                  bitline_q    <= data_q;
                  selectline_q <= ~data_q;
                  form_q       <= (op_q == OP_FORM);
               end
            end

            S_READ: begin
               state_q <= S_WAIT;
               cnt_q   <= 4'd1;
            end

            S_WAIT: begin
               if (cnt_q >= WAIT_LAST) begin
                  state_q     <= S_RESP;
                  cnt_q       <= 4'd0;
                  rsp_data_q  <= arr_out;
                  rsp_valid_q <= 1'b1;
                  wordline_q  <= 8'h00;
                  mac_q       <= 1'b0;
               end else begin
                  cnt_q      <= cnt_q + 4'd1;
                  wordline_q <= data_q;
               end
            end

            S_RESP: begin
               if (bus.rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   assign bitline       = bitline_q;
   assign wordline      = wordline_q;
   assign selectline    = selectline_q;
   assign wenable       = wenable_q;
   assign form          = form_q;
   assign mac           = mac_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crossbar_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossbar_seq
// Description : Directed self-checking bench for crossbar_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crossbar_seq;

   localparam int PC = 2;
   localparam int RL = 1;

   localparam logic [1:0] OP_PROG = 2'd0;
   localparam logic [1:0] OP_FORM = 2'd1;
   localparam logic [1:0] OP_MAC  = 2'd2;
   localparam logic [1:0] OP_RSV  = 2'd3;

   logic       clk;
   logic       rst;
   logic [7:0] bitline;
   logic [7:0] wordline;
   logic [7:0] selectline;
   logic       wenable;
   logic       form;
   logic       mac;
   logic [7:0] arr_out;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   crossbar_seq_if bus ();

   crossbar_seq #(
      .PULSE_CYCLES (PC),
      .READ_LAT     (RL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .bitline    (bitline),
      .wordline   (wordline),
      .selectline (selectline),
      .wenable    (wenable),
      .form       (form),
      .mac        (mac),
      .arr_out    (arr_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_arr(input string tag, input logic [7:0] wl, input logic [7:0] bl,
                          input logic [7:0] sl, input logic we, input logic fm, input logic mc);
      chk({tag, ".wordline"},   wordline,          wl);
      chk({tag, ".bitline"},    bitline,           bl);
      chk({tag, ".selectline"}, selectline,        sl);
      chk({tag, ".wenable"},    {7'd0, wenable},   {7'd0, we});
      chk({tag, ".form"},       {7'd0, form},      {7'd0, fm});
      chk({tag, ".mac"},        {7'd0, mac},       {7'd0, mc});
   endtask

   task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic rv);
      chk({tag, ".cmd_ready"}, {7'd0, bus.cmd_ready}, {7'd0, rdy});
      chk({tag, ".busy"},      {7'd0, busy},          {7'd0, bsy});
      chk({tag, ".rsp_valid"}, {7'd0, bus.rsp_valid}, {7'd0, rv});
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] row, input logic [7:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_row   = row;
      bus.cmd_data  = data;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int   n_acc;
      int   last;
      logic acc;

      rst           = 1'b1;
      arr_out       = 8'h00;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_row   = 3'd0;
      bus.cmd_data  = 8'h00;
      bus.rsp_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk_arr("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("reset", 1'b1, 1'b0, 1'b0);
      chk("reset.rsp_data", bus.rsp_data, 8'h00);
      rst = 1'b0;
      tick();
      chk_ctl("post_reset", 1'b1, 1'b0, 1'b0);

      // PROG row 3, data 0xA5: two pulse cycles
      issue(OP_PROG, 3'd3, 8'hA5);
      chk_arr("prog_c1", 8'h08, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
      chk_ctl("prog_c1", 1'b0, 1'b1, 1'b0);
      tick();
      chk_arr("prog_c2", 8'h08, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
      tick();
      chk_arr("prog_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("prog_end", 1'b1, 1'b0, 1'b0);

      // FORM row 0, data 0xFF
      issue(OP_FORM, 3'd0, 8'hFF);
      chk_arr("form_c1", 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      chk_arr("form_c2", 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      chk_arr("form_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("form_end", 1'b1, 1'b0, 1'b0);

      // MAC data 0x0F, arr_out 0x3C, consumer stalls
      arr_out = 8'h3C;
      issue(OP_MAC, 3'd0, 8'h0F);
      chk_arr("mac_read", 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_ctl("mac_read", 1'b0, 1'b1, 1'b0);
      tick();
      chk_arr("mac_wait", 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      arr_out = 8'h00;
      chk_arr("mac_resp", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("mac_resp", 1'b0, 1'b1, 1'b1);
      chk("mac_resp.rsp_data", bus.rsp_data, 8'h3C);
      tick();
      tick();
      tick();
      chk_ctl("mac_hold", 1'b0, 1'b1, 1'b1);
      chk("mac_hold.rsp_data", bus.rsp_data, 8'h3C);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk_ctl("mac_done", 1'b1, 1'b0, 1'b0);

      // Reset during second pulse cycle, with cmd_valid pending
      issue(OP_PROG, 3'd5, 8'h3C);
      tick();
      chk_arr("rstmid_c2", 8'h20, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_PROG;
      bus.cmd_row   = 3'd7;
      bus.cmd_data  = 8'hFF;
      tick();
      chk_arr("rstmid", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("rstmid", 1'b1, 1'b0, 1'b0);
      tick();
      chk_arr("rst_prio", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      bus.cmd_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk_ctl("rst_release", 1'b1, 1'b0, 1'b0);

      // MAC with zero vector after reset; consumer always ready
      arr_out = 8'h81;
      bus.rsp_ready = 1'b1;
      issue(OP_MAC, 3'd0, 8'h00);
      chk_arr("mac0_read", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk_arr("mac0_wait", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("mac0_resp", 1'b0, 1'b1, 1'b1);
      chk("mac0_resp.rsp_data", bus.rsp_data, 8'h81);
      tick();
      chk_ctl("mac0_done", 1'b1, 1'b0, 1'b0);
      bus.rsp_ready = 1'b0;

      // Back-to-back PROG rows 0..7 with cmd_valid held
      bus.cmd_op    = OP_PROG;
      bus.cmd_data  = 8'h55;
      bus.cmd_row   = 3'd0;
      bus.cmd_valid = 1'b1;
      n_acc = 0;
      last  = 0;
      for (int cyc = 1; cyc <= 40 && n_acc < 8; cyc++) begin
         acc = bus.cmd_valid && bus.cmd_ready;
         tick();
         if (acc) begin
            chk($sformatf("b2b_wl%0d", n_acc), wordline, 8'd1 << n_acc);
            if (n_acc > 0)
               chk($sformatf("b2b_gap%0d", n_acc), 8'(cyc - last), 8'(PC + 1));
            last  = cyc;
            n_acc = n_acc + 1;
            bus.cmd_row = 3'(n_acc);
            if (n_acc == 8)
               bus.cmd_valid = 1'b0;
         end
      end
      bus.cmd_valid = 1'b0;
      chk("b2b_count", 8'(n_acc), 8'd8);
      tick();
      tick();
      chk_ctl("b2b_end", 1'b1, 1'b0, 1'b0);

      // Reserved op: accepted, no activity
      chk_ctl("rsv_pre", 1'b1, 1'b0, 1'b0);
      issue(OP_RSV, 3'd7, 8'hFF);
      chk_arr("rsv_c1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("rsv_c1", 1'b1, 1'b0, 1'b0);
      tick();
      chk_arr("rsv_c2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_ctl("rsv_c2", 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
